// File: rtl/flash_arb_if.sv
// Requester and flash-macro bundle for flash_arb.
// slave: the arbiter side; master: requesters plus the flash macro.
interface flash_arb_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic [1:0]          req_valid_i;
    logic [1:0]          req_ready_o;
    logic [1:0][1:0]     req_op_i;
    logic [1:0][AW-1:0]  req_addr_i;
    logic [1:0][DW-1:0]  req_wdata_i;
    logic [1:0]          rsp_valid_o;
    logic [1:0]          rsp_ready_i;
    logic [DW-1:0]       rsp_rdata_o;
    logic                rsp_err_o;
    logic                flash_req_o;
    logic [1:0]          flash_op_o;
    logic [AW-1:0]       flash_addr_o;
    logic [DW-1:0]       flash_wdata_o;
    logic                flash_done_i;
    logic [DW-1:0]       flash_rdata_i;

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, flash_done_i, flash_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output flash_req_o, flash_op_o, flash_addr_o, flash_wdata_o
    );

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, flash_done_i, flash_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  flash_req_o, flash_op_o, flash_addr_o, flash_wdata_o
    );
endinterface

// File: rtl/flash_arb.sv
// Two-port round-robin arbiter in front of a single flash macro.
// Optional FLASH_ARB_TIMEOUT_EN aborts a stuck flash op after TimeoutCyc.
module flash_arb #(
    parameter int NumBanks     = 2,
    parameter int PagesPerBank = 8,
    parameter int WordsPerPage = 256,
    parameter int DW           = 32,
    parameter int TimeoutCyc   = 1024
) (
    input logic       clk_i,
    input logic       rst_i,
    flash_arb_if.slave bus
);
    localparam int AW    = $clog2(NumBanks * PagesPerBank * WordsPerPage);
    localparam int WBits = $clog2(WordsPerPage);
    localparam logic [AW-1:0] PageMask = {AW{1'b1}} << WBits;

    localparam logic [1:0] OpRead  = 2'd0;
    localparam logic [1:0] OpErase = 2'd2;
    localparam logic [1:0] OpRsvd  = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic            last;
    logic            port;
    logic            win;
    logic            grant;
    logic [1:0]      ready;
    logic [1:0]      gop;
    logic [AW-1:0]   gaddr;
    logic            freq;
    logic [1:0]      fop;
    logic [AW-1:0]   faddr;
    logic [DW-1:0]   fwdata;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            rerr;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TimeoutCyc + 1);
    logic [CW-1:0] cnt;
`endif

    // Pick the winner: sole requester, else the port not granted last.
    always_comb begin
        win = 1'b0;
        case (bus.req_valid_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
    end

    // Only the winner sees ready, and only while idle and out of reset.
    always_comb begin
        ready = 2'b00;
        if (state == IDLE && !rst_i && |bus.req_valid_i)
            ready[win] = 1'b1;
    end

    assign grant = |(bus.req_valid_i & ready);
    assign gop   = bus.req_op_i[win];
    assign gaddr = bus.req_addr_i[win];

    assign bus.req_ready_o   = ready;
    assign bus.rsp_valid_o   = rvalid;
    assign bus.rsp_rdata_o   = rdata;
    assign bus.rsp_err_o     = rerr;
    assign bus.flash_req_o   = freq;
    assign bus.flash_op_o    = fop;
    assign bus.flash_addr_o  = faddr;
    assign bus.flash_wdata_o = fwdata;

    // Main FSM with registered flash command and response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            last   <= 1'b1;
            port   <= 1'b0;
            freq   <= 1'b0;
            fop    <= '0;
            faddr  <= '0;
            fwdata <= '0;
            rvalid <= '0;
            rdata  <= '0;
            rerr   <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
            cnt    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        port <= win;
                        last <= win;
                        if (gop == OpRsvd) begin
                            rvalid      <= '0;
                            rvalid[win] <= 1'b1;
                            rdata       <= '0;
                            rerr        <= 1'b1;
                            state       <= RESP;
                        end else begin
                            freq   <= 1'b1;
                            fop    <= gop;
                            faddr  <= (gop == OpErase) ? (gaddr & PageMask)
                                                       : gaddr;
                            fwdata <= bus.req_wdata_i[win];
                            state  <= WAIT;
`ifdef FLASH_ARB_TIMEOUT_EN
                            cnt    <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    if (bus.flash_done_i) begin
                        freq         <= 1'b0;
                        rdata        <= (fop == OpRead) ? bus.flash_rdata_i
                                                        : '0;
                        rerr         <= 1'b0;
                        rvalid       <= '0;
                        rvalid[port] <= 1'b1;
                        state        <= RESP;
`ifdef FLASH_ARB_TIMEOUT_EN
                    end else if (cnt == CW'(TimeoutCyc - 1)) begin
                        freq         <= 1'b0;
                        rdata        <= '0;
                        rerr         <= 1'b1;
                        rvalid       <= '0;
                        rvalid[port] <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i[port]) begin
                        rvalid <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
